// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - memory-side responder with fixed-latency in-order response pipeline
module imem_responder #(
    parameter int bits            = 32,
    parameter int DEPTH_WORDS     = 1024,
    parameter int LATENCY         = 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                proc_req,
    input  logic                we,
    input  logic [bits/8-1:0]   be,
    input  logic [bits-1:0]     ADDR,
    input  logic [bits-1:0]     WDATA,
    output logic                mem_rdy,
    output logic                valid,
    output logic [bits-1:0]     RDATA,
    output logic                err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int NB = bits / 8;

    // First byte address past the array; one extra bit so large arrays cannot wrap the compare.
    localparam logic [bits:0]   ADDR_LIMIT = (bits + 1)'(DEPTH_WORDS) << 2;
    localparam logic [CW-1:0]   MAX_CNT    = CW'(MAX_OUTSTANDING);
    localparam logic [CW-1:0]   CNT_ONE    = CW'(1);

    // Storage array; deliberately has no reset so it maps onto plain RAM.
    logic [bits-1:0] mem [DEPTH_WORDS];

    logic [CW-1:0]   outstanding;
    logic            accept;
    logic            addr_err;
    logic [AW-1:0]   word_idx;
    logic            do_write;
    logic [bits-1:0] load_data;

    // Response pipeline: slot LATENCY-1 is the output register.
    logic [LATENCY-1:0] slot_occ;
    logic [LATENCY-1:0] slot_err;
    logic [bits-1:0]    slot_data [LATENCY];

    // Ready depends only on the registered counter, so no path from proc_req back to mem_rdy.
    assign mem_rdy = (outstanding < MAX_CNT);

    // Request decode: handshake, word index, address error and the word sampled for a read.
    always_comb begin
        accept    = proc_req && mem_rdy;
        word_idx  = ADDR[AW+1:2];
        addr_err  = (ADDR[1:0] != 2'b00) || ({1'b0, ADDR} >= ADDR_LIMIT);
        do_write  = accept && we && !addr_err;
        load_data = '0;
        if (accept && !we && !addr_err) begin
            load_data = mem[word_idx];
        end
    end

    // Byte-enabled write at the accepting edge; erroring requests never touch the array.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int b = 0; b < NB; b++) begin
                if (be[b]) begin
                    mem[word_idx][8*b +: 8] <= WDATA[8*b +: 8];
                end
            end
        end
    end

    // Shift pipeline carrying {occupied, err, data}; reset drops anything in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_occ <= '0;
            slot_err <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                slot_data[k] <= '0;
            end
        end else begin
            slot_occ[0]  <= accept;
            slot_err[0]  <= accept && addr_err;
            slot_data[0] <= load_data;
            for (int k = 1; k < LATENCY; k++) begin
                slot_occ[k]  <= slot_occ[k-1];
                slot_err[k]  <= slot_err[k-1];
                slot_data[k] <= slot_data[k-1];
            end
        end
    end

    // Count accepted-but-unanswered requests; a response retires at the end of its valid cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outstanding <= '0;
        end else begin
            case ({accept, valid})
                2'b10:   outstanding <= outstanding + CNT_ONE;
                2'b01:   outstanding <= outstanding - CNT_ONE;
                default: outstanding <= outstanding;
            endcase
        end
    end

    assign valid = slot_occ[LATENCY-1];
    assign err   = slot_err[LATENCY-1];
    assign RDATA = slot_data[LATENCY-1];

endmodule

// File: tb/tb_imem_responder.sv
// tb/tb_imem_responder.sv - scoreboard bench for imem_responder in two latency/depth configurations
module tb_imem_responder;

    localparam int LAT_A = 2;
    localparam int MAX_A = 4;
    localparam int LAT_B = 4;
    localparam int MAX_B = 2;

    typedef struct {
        logic [31:0] rdata;
        logic        e;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic        req_a = 1'b0, we_a = 1'b0, rdy_a, valid_a, err_a;
    logic [3:0]  be_a = 4'h0;
    logic [31:0] addr_a = '0, wdata_a = '0, rdata_a;
    logic        req_b = 1'b0, we_b = 1'b0, rdy_b, valid_b, err_b;
    logic [3:0]  be_b = 4'h0;
    logic [31:0] addr_b = '0, wdata_b = '0, rdata_b;

    int   compared   = 0;
    int   mismatched = 0;
    int   pcyc       = 0;
    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    int   w0, w1, w2, c0, c1, c2, wsum;

    imem_responder #(.bits(32), .DEPTH_WORDS(1024), .LATENCY(LAT_A), .MAX_OUTSTANDING(MAX_A)) dut_a (
        .clk(clk), .rst(rst), .proc_req(req_a), .we(we_a), .be(be_a), .ADDR(addr_a), .WDATA(wdata_a),
        .mem_rdy(rdy_a), .valid(valid_a), .RDATA(rdata_a), .err(err_a)
    );

    imem_responder #(.bits(32), .DEPTH_WORDS(1024), .LATENCY(LAT_B), .MAX_OUTSTANDING(MAX_B)) dut_b (
        .clk(clk), .rst(rst), .proc_req(req_b), .we(we_b), .be(be_b), .ADDR(addr_b), .WDATA(wdata_b),
        .mem_rdy(rdy_b), .valid(valid_b), .RDATA(rdata_b), .err(err_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) pcyc <= pcyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Present one request, hold it until accepted, and queue its expected response.
    task automatic issue(input int d, input logic w, input logic [3:0] b, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] xr, input logic xe, input bit push,
                         output int waits, output int acc);
        bit   got;
        exp_t x;
        got   = 0;
        waits = 0;
        acc   = 0;
        if (d == 0) begin
            req_a = 1'b1; we_a = w; be_a = b; addr_a = a; wdata_a = wd;
        end else begin
            req_b = 1'b1; we_b = w; be_b = b; addr_b = a; wdata_b = wd;
        end
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            if ((d == 0) ? rdy_a : rdy_b) begin
                got     = 1;
                acc     = pcyc;
                x.rdata = xr;
                x.e     = xe;
                x.due   = pcyc + ((d == 0) ? LAT_A : LAT_B);
                if (push) begin
                    if (d == 0) qa.push_back(x);
                    else        qb.push_back(x);
                end
            end else begin
                waits++;
            end
        end
        if (!got) begin
            compared++;
            mismatched++;
            $display("FAIL accept_timeout: dut %0d addr %h never accepted", d, a);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req_a = 1'b0;
        req_b = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor for configuration A: every valid pulse must match the oldest queued entry, on time.
    always @(negedge clk) begin
        if (rst) begin
            if (valid_a) begin
                if (qa.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_valid_a: got valid=1, expected none (t=%0t)", $time);
                end else begin
                    ea = qa.pop_front();
                    chk("rdata_a", rdata_a, ea.rdata);
                    chk("err_a", {31'b0, err_a}, {31'b0, ea.e});
                    chk("latency_a", pcyc, ea.due);
                end
            end else begin
                chk("idle_rdata_a", rdata_a, 32'h0);
            end
        end
    end

    // Monitor for configuration B.
    always @(negedge clk) begin
        if (rst) begin
            if (valid_b) begin
                if (qb.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_valid_b: got valid=1, expected none (t=%0t)", $time);
                end else begin
                    eb = qb.pop_front();
                    chk("rdata_b", rdata_b, eb.rdata);
                    chk("err_b", {31'b0, err_b}, {31'b0, eb.e});
                    chk("latency_b", pcyc, eb.due);
                end
            end else begin
                chk("idle_rdata_b", rdata_b, 32'h0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid_a", {31'b0, valid_a}, 32'h0);
        chk("rst_rdata_a", rdata_a, 32'h0);
        chk("rst_err_a", {31'b0, err_a}, 32'h0);
        chk("rst_valid_b", {31'b0, valid_b}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rdy_after_rst_a", {31'b0, rdy_a}, 32'h1);
        chk("rdy_after_rst_b", {31'b0, rdy_b}, 32'h1);
        @(posedge clk);
        #1;

        // Write then read the same word on consecutive cycles
        issue(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1, w0, c0);
        issue(0, 1'b0, 4'hF, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1, w0, c0);

        // Byte enables, including an all-zero enable
        issue(0, 1'b1, 4'hF, 32'h20, 32'h11223344, 32'h0, 1'b0, 1, w0, c0);
        issue(0, 1'b1, 4'b0010, 32'h20, 32'hAABBCCDD, 32'h0, 1'b0, 1, w0, c0);
        issue(0, 1'b0, 4'hF, 32'h20, 32'h0, 32'h1122CC44, 1'b0, 1, w0, c0);
        issue(0, 1'b1, 4'b0000, 32'h20, 32'hFFFFFFFF, 32'h0, 1'b0, 1, w0, c0);
        issue(0, 1'b0, 4'hF, 32'h20, 32'h0, 32'h1122CC44, 1'b0, 1, w0, c0);
        idle(4);

        // Streaming: preload then four back-to-back reads with no stall
        wsum = 0;
        for (int i = 0; i < 4; i++) begin
            issue(0, 1'b1, 4'hF, 32'(4 * i), 32'(i + 1), 32'h0, 1'b0, 1, w0, c0);
            wsum += w0;
        end
        for (int i = 0; i < 4; i++) begin
            issue(0, 1'b0, 4'hF, 32'(4 * i), 32'h0, 32'(i + 1), 1'b0, 1, w0, c0);
            wsum += w0;
        end
        chk("stream_stalls_a", 32'(wsum), 32'h0);

        // Erroring writes must not alter the array (out-of-range aliases word 0, misaligned aliases word 4)
        issue(0, 1'b1, 4'hF, 32'h1000, 32'h55555555, 32'h0, 1'b1, 1, w0, c0);
        issue(0, 1'b1, 4'hF, 32'h12, 32'h66666666, 32'h0, 1'b1, 1, w0, c0);
        issue(0, 1'b0, 4'hF, 32'h0, 32'h0, 32'h1, 1'b0, 1, w0, c0);
        issue(0, 1'b0, 4'hF, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1, w0, c0);
        idle(8);

        // Flow control on B (LATENCY=4, MAX_OUTSTANDING=2)
        issue(1, 1'b1, 4'hF, 32'h0, 32'h000000A0, 32'h0, 1'b0, 1, w0, c0);
        issue(1, 1'b1, 4'hF, 32'h4, 32'h000000A4, 32'h0, 1'b0, 1, w0, c0);
        issue(1, 1'b1, 4'hF, 32'h8, 32'h000000A8, 32'h0, 1'b0, 1, w0, c0);
        idle(10);
        issue(1, 1'b0, 4'hF, 32'h0, 32'h0, 32'h000000A0, 1'b0, 1, w0, c0);
        issue(1, 1'b0, 4'hF, 32'h4, 32'h0, 32'h000000A4, 1'b0, 1, w1, c1);
        issue(1, 1'b0, 4'hF, 32'h8, 32'h0, 32'h000000A8, 1'b0, 1, w2, c2);
        chk("flow_second_wait_b", 32'(w1), 32'h0);
        chk("flow_second_gap_b", 32'(c1 - c0), 32'h1);
        chk("flow_third_wait_b", 32'(w2), 32'h3);
        chk("flow_third_gap_b", 32'(c2 - c0), 32'h5);

        // Address errors on reads
        issue(1, 1'b0, 4'hF, 32'h6, 32'h0, 32'h0, 1'b1, 1, w0, c0);
        issue(1, 1'b0, 4'hF, 32'h1000, 32'h0, 32'h0, 1'b1, 1, w0, c0);
        idle(12);

        // Reset with two reads in flight: their responses must never appear
        issue(1, 1'b0, 4'hF, 32'h0, 32'h0, 32'h0, 1'b0, 0, w0, c0);
        issue(1, 1'b0, 4'hF, 32'h4, 32'h0, 32'h0, 1'b0, 0, w0, c0);
        req_b = 1'b0;
        rst   = 1'b0;
        @(negedge clk);
        chk("midrst_valid_b", {31'b0, valid_b}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(10);
        @(negedge clk);
        chk("midrst_rdy_b", {31'b0, rdy_b}, 32'h1);
        @(posedge clk);
        #1;
        issue(1, 1'b0, 4'hF, 32'h4, 32'h0, 32'h000000A4, 1'b0, 1, w0, c0);
        issue(1, 1'b0, 4'hF, 32'h8, 32'h0, 32'h000000A8, 1'b0, 1, w1, c1);
        chk("postrst_waits_b", 32'(w0 + w1), 32'h0);
        idle(12);

        chk("leftover_a", 32'(qa.size()), 32'h0);
        chk("leftover_b", 32'(qb.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
